// File: rtl/layer1_spike_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : layer1_spike_dispatcher
//  Description : Drains the layer-1 input FIFO and turns each data word into a
//                spike event for the layer-1 neuron core (valid/ready).
//                Handles the end-of-timestep marker and its FIFO echo word,
//                and keeps per-timestep spike statistics.
//  Options     : ADDR_RANGE_CHECK_EN - when defined, words addressing a
//                neuron >= NUM_NEURONS are dropped and counted, and the
//                range_err / drop_count outputs are added.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer1_spike_dispatcher #(
    parameter int               WIDTH       = 16,
    parameter int               ADDR_WIDTH  = 10,
    parameter int               NUM_NEURONS = 784,
    parameter int               TS_WIDTH    = 16,
    parameter int               CNT_WIDTH   = 11,
    parameter logic [WIDTH-1:0] EOT_MARK    = 16'hFAF1,
    parameter logic [WIDTH-1:0] ECHO_MARK   = 16'hF1FA
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [WIDTH-1:0]      fifo_rd_data,
    output logic                  spike_valid,
    input  logic                  spike_ready,
    output logic [ADDR_WIDTH-1:0] spike_addr,
    output logic                  ts_done,
    output logic [TS_WIDTH-1:0]   ts_count,
    output logic [CNT_WIDTH-1:0]  spike_count,
    output logic                  busy
`ifdef ADDR_RANGE_CHECK_EN
    ,
    output logic                  range_err,
    output logic [CNT_WIDTH-1:0]  drop_count
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        HOLD = 3'd2,
        EOT1 = 3'd3,
        EOT2 = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                  state;
    state_t                  state_next;
    logic [CNT_WIDTH-1:0]    run_cnt;

    logic [ADDR_WIDTH-1:0]   word_addr;
    logic                    word_is_eot;
    logic                    word_is_echo;
    logic                    addr_ok;
    logic                    accept_word;
    logic                    handshake;

    assign word_addr    = fifo_rd_data[ADDR_WIDTH-1:0];
    assign word_is_eot  = (fifo_rd_data == EOT_MARK);
    assign word_is_echo = (fifo_rd_data == ECHO_MARK);

`ifdef ADDR_RANGE_CHECK_EN
    // One extra bit so NUM_NEURONS == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] NEURON_LIMIT = (ADDR_WIDTH+1)'(NUM_NEURONS);
    assign addr_ok = ({1'b0, word_addr} < NEURON_LIMIT);
`else
    assign addr_ok = 1'b1;
`endif

    // A data word in WAIT becomes an event only if it is neither marker nor
    // echo and (when checked) addresses an existing neuron.
    assign accept_word = (state == WAIT) && !word_is_eot && !word_is_echo && addr_ok;
    assign handshake   = (state == HOLD) && spike_ready;

    assign ts_done = (state == EOT1);
    assign busy    = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and FIFO read request; reads are only ever issued from IDLE,
    // which also keeps the two cycles after a marker free of reads.
    always_comb begin
        state_next = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                fifo_rd_en = enable && !fifo_empty;
                if (enable && !fifo_empty) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (word_is_eot) begin
                    state_next = EOT1;
                end else if (accept_word) begin
                    state_next = HOLD;
                end else begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (spike_ready) begin
                    state_next = IDLE;
                end
            end
            EOT1:    state_next = EOT2;
            EOT2:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Event output register: loaded from the sampled word, held until accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            spike_valid <= 1'b0;
            spike_addr  <= '0;
        end else if (accept_word) begin
            spike_valid <= 1'b1;
            spike_addr  <= word_addr;
        end else if (handshake) begin
            spike_valid <= 1'b0;
        end
    end

    // Timestep statistics: running spike count, closed out on EOT1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_cnt     <= '0;
            ts_count    <= '0;
            spike_count <= '0;
        end else if (state == EOT1) begin
            ts_count    <= ts_count + 1'b1;
            spike_count <= run_cnt;
            run_cnt     <= '0;
        end else if (handshake && (run_cnt != CNT_MAX)) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

`ifdef ADDR_RANGE_CHECK_EN
    // Out-of-range words: one-cycle error pulse and a sticky saturating count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            range_err  <= 1'b0;
            drop_count <= '0;
        end else begin
            range_err <= (state == WAIT) && !word_is_eot && !word_is_echo && !addr_ok;
            if ((state == WAIT) && !word_is_eot && !word_is_echo && !addr_ok
                && (drop_count != CNT_MAX)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_layer1_spike_dispatcher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_layer1_spike_dispatcher
//  Description : Self-checking bench for layer1_spike_dispatcher with a FIFO
//                model (registered read data plus marker echo) and an event
//                scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_layer1_spike_dispatcher;

    localparam int AW = 10;
    localparam int TW = 16;
    localparam int CW = 11;
    localparam logic [15:0] EOT  = 16'hFAF1;
    localparam logic [15:0] ECHO = 16'hF1FA;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [15:0]   fifo_rd_data = 16'h0000;
    logic          spike_valid;
    logic          spike_ready = 1'b0;
    logic [AW-1:0] spike_addr;
    logic          ts_done;
    logic [TW-1:0] ts_count;
    logic [CW-1:0] spike_count;
    logic          busy;
`ifdef ADDR_RANGE_CHECK_EN
    logic          range_err;
    logic [CW-1:0] drop_count;
`endif

    int total = 0;
    int bad   = 0;

    layer1_spike_dispatcher dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .spike_valid  (spike_valid),
        .spike_ready  (spike_ready),
        .spike_addr   (spike_addr),
        .ts_done      (ts_done),
        .ts_count     (ts_count),
        .spike_count  (spike_count),
        .busy         (busy)
`ifdef ADDR_RANGE_CHECK_EN
        ,
        .range_err    (range_err),
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- FIFO model ----------------
    logic [15:0] fq[$];
    logic [15:0] popped;
    int          echo_cnt = 0;

    // Registered read data; a popped marker is overwritten by its echo two edges later.
    always @(posedge clk) begin
        if (echo_cnt > 0) begin
            echo_cnt--;
            if (echo_cnt == 0) fifo_rd_data <= ECHO;
        end
        if (fifo_rd_en) begin
            if (fq.size() == 0) begin
                fail_now("read_while_empty");
            end else begin
                popped = fq.pop_front();
                fifo_rd_data <= popped;
                if (popped == EOT) echo_cnt = 2;
            end
        end
        fifo_empty <= (fq.size() == 0);
    end

    // ---------------- reference model / scoreboard ----------------
    logic [AW-1:0] exp_q[$];
    int exp_ts = 0, exp_sc = 0, running = 0, exp_drop = 0;
    int exp_pulses = 0, exp_rerr = 0;

    task automatic push_word(input logic [15:0] w, input logic is_spike, input logic [AW-1:0] a);
        if (w == EOT) begin
            exp_ts     = (exp_ts + 1) % 65536;
            exp_sc     = running;
            running    = 0;
            exp_pulses++;
        end else if (w == ECHO) begin
            // echo words never produce anything
        end else if (is_spike) begin
            exp_q.push_back(a);
            if (running < 2047) running++;
        end else begin
            if (exp_drop < 2047) exp_drop++;
            exp_rerr++;
        end
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // ---------------- output monitor ----------------
    int            hs_cnt = 0, ts_pulses = 0, rerr_cnt = 0;
    logic          prev_v = 1'b0, prev_r = 1'b0, prev_ts = 1'b0;
    logic [AW-1:0] prev_a = '0;
    logic [AW-1:0] want;

    // Event ordering, hold stability, and read blackout around the marker.
    always @(negedge clk) begin
        if (rstn) begin
            if (prev_v && !prev_r) begin
                check("hold_valid_stable", 32'(spike_valid), 32'd1);
                check("hold_addr_stable", 32'(spike_addr), 32'(prev_a));
            end
            if (ts_done || prev_ts) check("eot_blackout_rd_en", 32'(fifo_rd_en), 32'd0);
            if (spike_valid && spike_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_event");
                end else begin
                    want = exp_q.pop_front();
                    check("event_addr", 32'(spike_addr), 32'(want));
                end
            end
            if (ts_done) ts_pulses++;
`ifdef ADDR_RANGE_CHECK_EN
            if (range_err) rerr_cnt++;
`endif
            prev_v  <= spike_valid;
            prev_r  <= spike_ready;
            prev_a  <= spike_addr;
            prev_ts <= ts_done;
        end else begin
            prev_v  <= 1'b0;
            prev_r  <= 1'b0;
            prev_ts <= 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (!(fq.size() == 0 && fifo_empty && !busy && exp_q.size() == 0) && n < 300) begin
            step();
            n++;
        end
        check("drain_in_budget", 32'(n < 300), 32'd1);
        repeat (3) step();
    endtask

    task automatic check_stats();
        check("ts_count", 32'(ts_count), 32'(exp_ts));
        check("spike_count", 32'(spike_count), 32'(exp_sc));
        check("ts_done_pulses", 32'(ts_pulses), 32'(exp_pulses));
`ifdef ADDR_RANGE_CHECK_EN
        check("drop_count", 32'(drop_count), 32'(exp_drop));
        check("range_err_pulses", 32'(rerr_cnt), 32'(exp_rerr));
`endif
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!spike_valid && n < 20) begin
            step();
            n++;
        end
        check(name, 32'(spike_valid), 32'd1);
    endtask

    typedef struct {
        logic [15:0]   word;
        logic          is_spike;
        logic [AW-1:0] addr;
        logic          last;
    } vec_t;

    vec_t vecs[12];
    int   h0;

    initial begin
        vecs[0]  = '{16'h0005, 1'b1, 10'd5,   1'b0};
        vecs[1]  = '{16'h0010, 1'b1, 10'd16,  1'b0};
        vecs[2]  = '{EOT,      1'b0, 10'd0,   1'b1};
        vecs[3]  = '{EOT,      1'b0, 10'd0,   1'b0};
        vecs[4]  = '{EOT,      1'b0, 10'd0,   1'b1};
        vecs[5]  = '{ECHO,     1'b0, 10'd0,   1'b0};
        vecs[6]  = '{16'h0007, 1'b1, 10'd7,   1'b0};
        vecs[7]  = '{EOT,      1'b0, 10'd0,   1'b1};
        vecs[8]  = '{16'hA405, 1'b1, 10'd5,   1'b0};
`ifdef ADDR_RANGE_CHECK_EN
        vecs[9]  = '{16'h0310, 1'b0, 10'd0,   1'b0};
`else
        vecs[9]  = '{16'h0310, 1'b1, 10'd784, 1'b0};
`endif
        vecs[10] = '{16'h030F, 1'b1, 10'd783, 1'b0};
        vecs[11] = '{EOT,      1'b0, 10'd0,   1'b1};

        // Reset state
        repeat (3) step();
        check("rst_spike_valid", 32'(spike_valid), 32'd0);
        check("rst_spike_addr", 32'(spike_addr), 32'd0);
        check("rst_ts_done", 32'(ts_done), 32'd0);
        check("rst_ts_count", 32'(ts_count), 32'd0);
        check("rst_spike_count", 32'(spike_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        step();
        enable      = 1'b1;
        spike_ready = 1'b1;

        // Table: data words, back-to-back markers, echo, upper bits, range edge
        for (int i = 0; i < 12; i++) begin
            push_word(vecs[i].word, vecs[i].is_spike, vecs[i].addr);
            if (vecs[i].last) begin
                drain();
                check_stats();
            end
        end

        // Back-pressure: event held while ready is low, no reads meanwhile
        spike_ready = 1'b0;
        push_word(16'h0003, 1'b1, 10'd3);
        push_word(16'h0004, 1'b1, 10'd4);
        wait_valid("hold_seen_valid");
        repeat (10) begin
            step();
            check("hold_valid", 32'(spike_valid), 32'd1);
            check("hold_addr", 32'(spike_addr), 32'd3);
            check("hold_no_read", 32'(fifo_rd_en), 32'd0);
        end
        h0 = hs_cnt;
        spike_ready = 1'b1;
        drain();
        check("hold_transfers", 32'(hs_cnt - h0), 32'd2);

        // enable low blocks reads; raising it drains in order
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push_word(16'h0011 + 16'(i), 1'b1, 10'h011 + 10'(i));
        repeat (8) begin
            step();
            check("disabled_no_read", 32'(fifo_rd_en), 32'd0);
        end
        h0 = hs_cnt;
        enable = 1'b1;
        drain();
        check("enabled_drained", 32'(hs_cnt - h0), 32'd4);
        check_stats();

        // Asynchronous reset during HOLD
        spike_ready = 1'b0;
        push_word(16'h0009, 1'b1, 10'd9);
        wait_valid("pre_reset_valid");
        rstn = 1'b0;
        #1;
        check("arst_spike_valid", 32'(spike_valid), 32'd0);
        check("arst_ts_count", 32'(ts_count), 32'd0);
        check("arst_spike_count", 32'(spike_count), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
`ifdef ADDR_RANGE_CHECK_EN
        check("arst_drop_count", 32'(drop_count), 32'd0);
`endif
        fq.delete();
        fifo_empty = 1'b1;
        exp_q.delete();
        exp_ts   = 0;
        exp_sc   = 0;
        running  = 0;
        exp_drop = 0;
        step();
        rstn = 1'b1;
        spike_ready = 1'b1;
        step();
        push_word(16'h0021, 1'b1, 10'h021);
        push_word(EOT, 1'b0, 10'd0);
        drain();
        check_stats();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
